// File: rtl/el_link_tx.sv
// el_link_tx: clocked source of the elastic delay-insensitive link.
// Accepts binary words on valid/ready, encodes every B-bit digit into a
// 1-of-RAIL_NUM code and drives it onto the link with a 4-phase
// return-to-zero handshake against the asynchronous ack_i.
// Optional feature macro: EL_LINK_TX_SKID_EN adds a one-entry skid buffer
// so one word can be accepted while a previous one is still on the link.
module el_link_tx #(
    parameter  int unsigned LINK_WIDTH  = 2,
    parameter  int unsigned RAIL_NUM    = 2,
    parameter  int unsigned SYNC_STAGES = 2,
    localparam int unsigned B           = $clog2(RAIL_NUM),
    localparam int unsigned DATA_W      = LINK_WIDTH * B,
    localparam int unsigned OUT_W       = LINK_WIDTH * RAIL_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              ack_i,
    output logic [OUT_W-1:0]  out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        SPACER = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_d;
    logic [OUT_W-1:0]       out_d;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   accept;

    // One-hot encode each digit: value v raises rail v of that digit only.
    function automatic logic [OUT_W-1:0] enc(input logic [DATA_W-1:0] w);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int unsigned d = 0; d < LINK_WIDTH; d++) begin
            r = r | (OUT_W'(1) << (d * RAIL_NUM + 32'(w[d*B +: B])));
        end
        return r;
    endfunction

    // Synchronizer chain bringing the asynchronous acknowledge into clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
        end
    end

    assign ack_s  = ack_sync[SYNC_STAGES-1];
    assign busy   = (state != IDLE);
    assign accept = s_valid && s_ready;

`ifdef EL_LINK_TX_SKID_EN
    logic              skid_full;
    logic              skid_full_d;
    logic [OUT_W-1:0]  skid_code;
    logic [OUT_W-1:0]  skid_code_d;

    // Skid build: ready depends only on buffer occupancy.
    assign s_ready = !rst && !skid_full;

    // Skid entry, stored already encoded so a launch is a plain copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_full <= 1'b0;
            skid_code <= '0;
        end else begin
            skid_full <= skid_full_d;
            skid_code <= skid_code_d;
        end
    end

    // Next-state, next-rail and skid-buffer logic.
    always_comb begin
        state_d     = state;
        out_d       = out;
        skid_full_d = skid_full;
        skid_code_d = skid_code;
        unique case (state)
            IDLE: begin
                if (!ack_s && skid_full) begin
                    out_d       = skid_code;
                    skid_full_d = 1'b0;
                    state_d     = DATA;
                end else if (accept) begin
                    if (!ack_s) begin
                        out_d   = enc(s_data);
                        state_d = DATA;
                    end else begin
                        // Stale ack: park the word until the link is clear.
                        skid_code_d = enc(s_data);
                        skid_full_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    skid_code_d = enc(s_data);
                    skid_full_d = 1'b1;
                end
                if (ack_s) begin
                    out_d   = '0;
                    state_d = SPACER;
                end
            end
            SPACER: begin
                out_d = '0;
                if (accept) begin
                    skid_code_d = enc(s_data);
                    skid_full_d = 1'b1;
                end
                if (!ack_s) begin
                    if (skid_full) begin
                        // Back-to-back launch skips IDLE.
                        out_d       = skid_code;
                        skid_full_d = 1'b0;
                        state_d     = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                out_d   = '0;
                state_d = IDLE;
            end
        endcase
    end
`else
    // Stop-and-wait: ready only in IDLE with a clear acknowledge.
    assign s_ready = !rst && (state == IDLE) && !ack_s;

    // Next-state and next-rail logic of the 4-phase handshake.
    always_comb begin
        state_d = state;
        out_d   = out;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    out_d   = enc(s_data);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ack_s) begin
                    out_d   = '0;
                    state_d = SPACER;
                end
            end
            SPACER: begin
                out_d = '0;
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                out_d   = '0;
                state_d = IDLE;
            end
        endcase
    end
`endif

    // State and link rails; rails come straight from these flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
        end else begin
            state <= state_d;
            out   <= out_d;
        end
    end

endmodule
